// File: rtl/route_pkg.sv
// Shared route encoding, select constants and the priority route decoder
// for the route_demux slice.
package route_pkg;

    typedef enum logic [1:0] {
        ROUTE_P0 = 2'd0,
        ROUTE_P1 = 2'd1,
        ROUTE_P2 = 2'd2
    } route_e;

    localparam int unsigned NUM_PORTS = 3;

    localparam logic [3:0] SEL_P0    = 4'h1;
    localparam logic [3:0] SEL_P1_LO = 4'h2;
    localparam logic [3:0] SEL_P1_HI = 4'h3;

    // en only qualifies the port-0 term; everything unmatched falls to port 2.
    function automatic route_e route_decode(input logic [3:0] sel, input logic en);
        if (sel == SEL_P0 && en) begin
            return ROUTE_P0;
        end else if (sel == SEL_P1_LO || sel == SEL_P1_HI) begin
            return ROUTE_P1;
        end
        return ROUTE_P2;
    endfunction

endpackage

// File: rtl/route_demux_if.sv
// Handshake bundle of route_demux: one input stream, three output ports
// with payload and transfer counters.
interface route_demux_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
);
    logic          valid_i;
    logic          ready_o;
    logic [3:0]    sel_i;
    logic          en_i;
    logic [DW-1:0] data_i;
    logic [2:0]    valid_o;
    logic [2:0]    ready_i;
    logic [DW-1:0] data0_o;
    logic [DW-1:0] data1_o;
    logic [DW-1:0] data2_o;
    logic [CW-1:0] cnt0_o;
    logic [CW-1:0] cnt1_o;
    logic [CW-1:0] cnt2_o;

    modport slave (
        input  valid_i, sel_i, en_i, data_i, ready_i,
        output ready_o, valid_o, data0_o, data1_o, data2_o, cnt0_o, cnt1_o, cnt2_o
    );

    modport master (
        output valid_i, sel_i, en_i, data_i, ready_i,
        input  ready_o, valid_o, data0_o, data1_o, data2_o, cnt0_o, cnt1_o, cnt2_o
    );
endinterface

// File: rtl/route_slot.sv
// One-entry output buffer with a wrapping transfer counter; a drain and a
// refill may happen in the same cycle.
module route_slot #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          free_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] cnt_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          xfer;

    always_comb begin
        xfer    = valid_q && ready_i;
        free_o  = !valid_q || ready_i;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + 1'b1;
        end
        // A refill wins over the drain so the slot stays full with new data.
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;
endmodule

// File: rtl/route_demux.sv
// One-to-three stream demultiplexer: priority route decode feeding three
// independent one-entry output slots.
module route_demux
    import route_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    route_demux_if.slave bus
);
    route_e              route;
    logic [2:0]          free;
    logic [2:0]          load;
    logic                accept;
    logic [2:0]          valid;
    logic [DW-1:0]       data [NUM_PORTS];
    logic [CW-1:0]       cnt  [NUM_PORTS];

    // ready never looks at valid_i, only at the decoded target's slot.
    always_comb begin
        route = route_decode(bus.sel_i, bus.en_i);
        unique case (route)
            ROUTE_P0: bus.ready_o = free[0];
            ROUTE_P1: bus.ready_o = free[1];
            default:  bus.ready_o = free[2];
        endcase
        accept  = bus.valid_i && bus.ready_o;
        load    = 3'b000;
        load[0] = accept && (route == ROUTE_P0);
        load[1] = accept && (route == ROUTE_P1);
        load[2] = accept && (route == ROUTE_P2);
    end

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
        route_slot #(
            .DW(DW),
            .CW(CW)
        ) u_slot (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .load_i (load[k]),
            .data_i (bus.data_i),
            .ready_i(bus.ready_i[k]),
            .free_o (free[k]),
            .valid_o(valid[k]),
            .data_o (data[k]),
            .cnt_o  (cnt[k])
        );
    end

    assign bus.valid_o = valid;
    assign bus.data0_o = data[0];
    assign bus.data1_o = data[1];
    assign bus.data2_o = data[2];
    assign bus.cnt0_o  = cnt[0];
    assign bus.cnt1_o  = cnt[1];
    assign bus.cnt2_o  = cnt[2];
endmodule

// File: tb/tb_route_demux.sv
// Self-checking bench for route_demux: directed scenarios with literal
// expectations, then randomized traffic against a slot-level reference model.
module tb_route_demux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    route_demux_if #(.DW(8), .CW(8)) bus ();

    route_demux #(
        .DW(8),
        .CW(8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per port a full flag, held payload and transfer count.
    bit         m_full [3];
    logic [7:0] m_data [3];
    logic [7:0] m_cnt  [3];
    logic       last_ready;

    function automatic int exp_route(input logic [3:0] s, input logic e);
        if (s == 4'd1 && e) return 0;
        if (s == 4'd2 || s == 4'd3) return 1;
        return 2;
    endfunction

    function automatic bit exp_ready(input logic [3:0] s, input logic e, input logic [2:0] r);
        int t;
        t = exp_route(s, e);
        return !m_full[t] || r[t];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = 8'h00;
            m_cnt[k]  = 8'h00;
        end
    endtask

    task automatic compare_model();
        check("valid_o", {29'd0, bus.valid_o}, {29'd0, m_full[2], m_full[1], m_full[0]});
        check("data0_o", {24'd0, bus.data0_o}, {24'd0, m_data[0]});
        check("data1_o", {24'd0, bus.data1_o}, {24'd0, m_data[1]});
        check("data2_o", {24'd0, bus.data2_o}, {24'd0, m_data[2]});
        check("cnt0_o", {24'd0, bus.cnt0_o}, {24'd0, m_cnt[0]});
        check("cnt1_o", {24'd0, bus.cnt1_o}, {24'd0, m_cnt[1]});
        check("cnt2_o", {24'd0, bus.cnt2_o}, {24'd0, m_cnt[2]});
        check("ready_o", {31'd0, bus.ready_o},
              {31'd0, exp_ready(bus.sel_i, bus.en_i, bus.ready_i)});
    endtask

    // One clock: drive at negedge, compare against the model, then advance it.
    task automatic tick(input bit v, input logic [3:0] sel, input bit en,
                        input logic [7:0] d, input logic [2:0] rdy);
        bit acc;
        int t;
        @(negedge clk);
        bus.valid_i = v;
        bus.sel_i   = sel;
        bus.en_i    = en;
        bus.data_i  = d;
        bus.ready_i = rdy;
        #1;
        compare_model();
        last_ready = bus.ready_o;
        acc = v && exp_ready(sel, en, rdy);
        t   = exp_route(sel, en);
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (m_full[k] && rdy[k]) begin
                    m_cnt[k]  = m_cnt[k] + 8'd1;
                    m_full[k] = 1'b0;
                end
            end
            if (acc) begin
                m_full[t] = 1'b1;
                m_data[t] = d;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = $urandom_range(0, 7);
        #1;
        model_reset();
        compare_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.sel_i   = 4'h0;
        bus.en_i    = 1'b0;
        bus.data_i  = 8'h00;
        bus.ready_i = 3'b111;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {29'd0, bus.valid_o}, 32'h0);
        check("rst_ready", {31'd0, bus.ready_o}, 32'h1);
        check("rst_cnt0", {24'd0, bus.cnt0_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Port 0 hit, latency 1, then one transfer.
        tick(1, 4'h1, 1, 8'hA5, 3'b111);
        #2;
        check("p0_valid", {29'd0, bus.valid_o}, 32'h1);
        check("p0_data", {24'd0, bus.data0_o}, 32'hA5);
        tick(0, 4'h0, 0, 8'h00, 3'b111);
        #2;
        check("p0_cnt", {24'd0, bus.cnt0_o}, 32'h1);

        // en only qualifies the port-0 term.
        tick(1, 4'h1, 0, 8'h3C, 3'b111);
        #2;
        check("sel1_en0_valid", {29'd0, bus.valid_o}, 32'h4);
        check("sel1_en0_data", {24'd0, bus.data2_o}, 32'h3C);
        tick(1, 4'h3, 0, 8'h77, 3'b111);
        #2;
        check("sel3_valid", {29'd0, bus.valid_o}, 32'h2);
        check("sel3_data", {24'd0, bus.data1_o}, 32'h77);

        // Back-to-back port-0 refills with concurrent drain.
        tick(1, 4'h1, 1, 8'h10, 3'b111);
        for (int i = 0; i < 4; i++) begin
            tick(1, 4'h1, 1, 8'h20 + 8'(i), 3'b111);
            check("refill_ready", {31'd0, last_ready}, 32'h1);
        end
        #2;
        check("refill_cnt0", {24'd0, bus.cnt0_o}, 32'h5);
        check("refill_data0", {24'd0, bus.data0_o}, 32'h23);
        tick(0, 4'h0, 0, 8'h00, 3'b111);

        // Stalled port 1 must not block port 2.
        tick(1, 4'h2, 0, 8'h11, 3'b101);
        #2;
        check("stall_data1", {24'd0, bus.data1_o}, 32'h11);
        tick(1, 4'h2, 0, 8'h22, 3'b101);
        check("stall_ready", {31'd0, last_ready}, 32'h0);
        #2;
        check("stall_hold", {24'd0, bus.data1_o}, 32'h11);
        tick(1, 4'h0, 0, 8'h33, 3'b101);
        check("bypass_ready", {31'd0, last_ready}, 32'h1);
        #2;
        check("bypass_data2", {24'd0, bus.data2_o}, 32'h33);
        check("bypass_hold1", {24'd0, bus.data1_o}, 32'h11);
        check("bypass_valid1", {31'd0, bus.valid_o[1]}, 32'h1);
        tick(0, 4'h0, 0, 8'h00, 3'b111);

        // Counter wrap on port 2.
        guard = 0;
        while (m_cnt[2] != 8'hFF && guard < 600) begin
            tick(1, 4'h0, 0, 8'($urandom), 3'b111);
            guard++;
        end
        #2;
        check("cnt2_ff", {24'd0, bus.cnt2_o}, 32'hFF);
        tick(0, 4'h0, 0, 8'h00, 3'b111);
        #2;
        check("cnt2_wrap", {24'd0, bus.cnt2_o}, 32'h0);

        // Reset with all slots full discards the words.
        tick(0, 4'h0, 0, 8'h00, 3'b111);
        tick(1, 4'h1, 1, 8'hA1, 3'b000);
        tick(1, 4'h2, 0, 8'hA2, 3'b000);
        tick(1, 4'h0, 0, 8'hA3, 3'b000);
        #2;
        check("full_valid", {29'd0, bus.valid_o}, 32'h7);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 3'b111;
        #1;
        check("mid_rst_valid", {29'd0, bus.valid_o}, 32'h0);
        check("mid_rst_ready", {31'd0, bus.ready_o}, 32'h1);
        check("mid_rst_cnt0", {24'd0, bus.cnt0_o}, 32'h0);
        check("mid_rst_data1", {24'd0, bus.data1_o}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 4'h0, 0, 8'h00, 3'b111);
        #2;
        check("post_rst_cnt", {8'd0, bus.cnt0_o, bus.cnt1_o, bus.cnt2_o}, 32'h0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                logic [3:0] s;
                logic [2:0] r;
                s = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
                for (int k = 0; k < 3; k++) r[k] = ($urandom_range(0, 3) != 0);
                tick($urandom_range(0, 3) != 0, s, 1'($urandom), 8'($urandom), r);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/route_demux.md
ROUTE_DEMUX -- requirements
Module: route_demux

Interface
REQ-001 Parameter DW, default 8, data width of input and all output channels.
REQ-002 Parameter CW, default 8, width of each per-port transfer counter.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 valid_i  input  1  input word offered.
REQ-006 ready_o  output  1  input word accepted when valid_i && ready_o.
REQ-007 sel_i  input  4  route select, sampled with the word.
REQ-008 en_i  input  1  route qualifier, sampled with the word.
REQ-009 data_i  input  DW  input payload.
REQ-010 valid_o  output  3  per-port output valid; bit k is port k.
REQ-011 ready_i  input  3  per-port downstream ready; bit k is port k.
REQ-012 data0_o / data1_o / data2_o  output  DW each  port 0/1/2 payload.
REQ-013 cnt0_o / cnt1_o / cnt2_o  output  CW each  completed output transfers per port.

Function
REQ-014 Route decode SHALL be priority-ordered: (sel_i==4'h1 && en_i) -> port 0; else (sel_i==4'h2 || sel_i==4'h3) -> port 1; else port 2.
REQ-015 en_i SHALL affect only the port-0 term; sel_i 2/3 with en_i=0 SHALL still route to port 1; sel_i 1 with en_i=0 SHALL route to port 2.
REQ-016 Each port SHALL hold a one-entry output slot (empty/full).
REQ-017 ready_o SHALL be 1 iff the decoded target slot is empty, or full with its ready_i bit high (same-cycle drain and refill).
REQ-018 ready_o SHALL depend combinationally on sel_i, en_i, slot states and ready_i only, never on valid_i.
REQ-019 On accept, the word SHALL be written to the target slot; valid_o[k] SHALL rise the next cycle (latency 1); only one slot written per cycle.
REQ-020 Port k transfer SHALL occur when valid_o[k] && ready_i[k]; slot then empties unless refilled that same cycle.
REQ-021 While valid_o[k]=1 and ready_i[k]=0, data_k_o SHALL be held stable.
REQ-022 Ports SHALL be independent: a stalled port SHALL NOT block words routed to other ports.
REQ-023 data_k_o SHALL retain the last loaded value when the slot is empty.
REQ-024 cnt_k_o SHALL increment by 1 on each port-k transfer, wrapping from 2^CW-1 to 0.
REQ-025 Simultaneous drain and refill of one slot SHALL increment cnt_k_o once and keep valid_o[k]=1 with new data.

Reset
REQ-026 On rst_ni low, at any time including mid-transfer: valid_o=3'b000, all data_k_o=0, all cnt_k_o=0, all slots empty.
REQ-027 Words held in slots at reset SHALL be discarded, not counted.
REQ-028 ready_o SHALL follow REQ-017 during and after reset (all slots empty, so 1).

Structure
REQ-029 Package route_pkg SHALL hold enum route_e {ROUTE_P0, ROUTE_P1, ROUTE_P2} (2-bit), the select constants 4'h1/4'h2/4'h3, and the decode function.
REQ-030 Sub-module route_slot (one-entry buffer plus wrapping counter, parameters DW/CW) SHALL be instantiated three times.

Verification
REQ-031 sel=1,en=1,data=8'hA5, all ready_i=1 -> valid_o=3'b001 next cycle, data0_o=8'hA5, cnt0_o=1.
REQ-032 sel=1,en=0,data=8'h3C -> port 2 receives 8'h3C; sel=3,en=0,data=8'h77 -> port 1 receives 8'h77.
REQ-033 ready_i[1]=0, two words sel=2 -> first held on port 1, ready_o=0 for second, data1_o stable; then sel=0 word accepted to port 2 meanwhile.
REQ-034 Port 0 full, ready_i[0]=1, new sel=1,en=1 word each cycle for 4 cycles -> ready_o=1 throughout, 4 transfers, cnt0_o=4.
REQ-035 cnt2_o driven to 8'hFF, one more port-2 transfer -> cnt2_o=8'h00.
REQ-036 rst_ni low for one cycle with all slots full -> valid_o=0, counts 0, ready_o=1, no transfer counted.
